// File: rtl/iiitb_rc.sv
// rtl/iiitb_rc.sv - loadable rotate-left ring counter with asynchronous seed load
module iiitb_rc #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] init,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] ring_q;
   logic [WIDTH-1:0] ring_d;

   // Next ring state: rotate left by one, MSB wraps into bit 0.
   always_comb begin
      ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
   end

   // Ring register: seed loaded on reset assertion and on every clock while
   // reset is held, so the seed present at the last edge before release is kept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ring_q <= init;
      end else begin
         ring_q <= ring_d;
      end
   end

   // While reset is low the output follows init directly, so a seed change
   // during reset is visible without any clock.
   always_comb begin
      out = reset ? ring_q : init;
   end

endmodule

// File: tb/tb_iiitb_rc.sv
// tb/tb_iiitb_rc.sv - self-checking bench for iiitb_rc against a rotation-count model
module tb_iiitb_rc;

   logic       clk;
   logic       reset;
   logic [3:0] init;
   logic [3:0] out;

   int errors;
   int checks;

   logic [3:0] seed;
   int         steps;

   iiitb_rc #(.WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .init  (init),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output: the seed rotated left by (steps mod 4) positions.
   function automatic logic [3:0] model(input logic [3:0] s, input int n);
      logic [7:0] d;
      d = {s, s};
      d = d << (n % 4);
      return d[7:4];
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance one clock and check the rotation against the model.
   task automatic step_check(input string tag);
      @(posedge clk);
      #1;
      steps++;
      check(tag, out, model(seed, steps));
   endtask

   // Assert reset mid-cycle with a new seed, hold it over one edge, release.
   task automatic load_seed(input logic [3:0] s);
      @(negedge clk);
      init  = s;
      reset = 1'b0;
      #1;
      check("async_load", out, s);
      @(posedge clk);
      #1;
      check("held_reset", out, s);
      reset = 1'b1;
      #1;
      seed  = s;
      steps = 0;
      check("after_release", out, s);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      steps  = 0;
      reset  = 1'b1;
      init   = 4'b0010;

      // Basic one-hot rotation through 17 edges.
      #2;
      reset = 1'b0;
      #1;
      check("reset_state", out, 4'b0010);
      @(posedge clk);
      #1;
      check("reset_hold", out, 4'b0010);
      reset = 1'b1;
      seed  = 4'b0010;
      steps = 0;
      #1;
      check("release_no_rotate", out, 4'b0010);
      step_check("rot_first_0100");
      check("rot_first_const", out, 4'b0100);
      for (int i = 0; i < 16; i++) step_check("rot_period");
      check("rot_17_const", out, 4'b0100);

      // Asynchronous load and tracking without a clock.
      @(negedge clk);
      init  = 4'b1000;
      reset = 1'b0;
      #1;
      check("async_1000", out, 4'b1000);
      init = 4'b0001;
      #1;
      check("track_0001", out, 4'b0001);
      init = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("hold_0100", out, 4'b0100);
      end
      reset = 1'b1;
      seed  = 4'b0100;
      steps = 0;
      step_check("resume_from_0100");

      // Reset in the middle of a run.
      load_seed(4'b0010);
      for (int i = 0; i < 5; i++) step_check("midrun_rot");
      check("midrun_0100", out, 4'b0100);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrun_reload", out, 4'b0010);
      #2;
      reset = 1'b1;
      seed  = 4'b0010;
      steps = 0;
      step_check("midrun_resume");
      check("midrun_resume_const", out, 4'b0100);
      step_check("midrun_resume2");
      check("midrun_resume2_const", out, 4'b1000);

      // Non-one-hot seeds rotate unchanged.
      load_seed(4'b1011);
      step_check("multi_hot");
      check("multi_hot_0111", out, 4'b0111);
      for (int i = 0; i < 7; i++) step_check("multi_hot");
      load_seed(4'b0000);
      for (int i = 0; i < 6; i++) step_check("all_zero");
      check("all_zero_const", out, 4'b0000);
      load_seed(4'b1111);
      for (int i = 0; i < 6; i++) step_check("all_one");
      check("all_one_const", out, 4'b1111);

      // init is ignored while running.
      load_seed(4'b0001);
      init = 4'b1111;
      step_check("init_ignored");
      check("init_ignored_0010", out, 4'b0010);
      for (int i = 0; i < 3; i++) step_check("init_ignored");
      check("init_ignored_0001", out, 4'b0001);

      // Randomized seeds, run lengths and init disturbances.
      for (int r = 0; r < 25; r++) begin
         load_seed(4'($urandom_range(0, 15)));
         for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
            init = 4'($urandom_range(0, 15));
            step_check("random_run");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the bench always ends.
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
